// File: rtl/xpmwrap_pkg.sv
// Shared definitions for the xpmwrap FIFO wrapper family.
// Read latency, width helper and stream beat type used by the read-side adapters.
package xpmwrap_pkg;

  localparam int unsigned XPMWRAP_RD_LATENCY = 1;
  localparam int unsigned XPMWRAP_BEAT_WIDTH = 32;

  typedef struct packed {
    logic [XPMWRAP_BEAT_WIDTH-1:0] data;
    logic                          last;
  } xpmwrap_beat_t;

  // ceil(log2(n)), but never below 1 so that 1-entry structures still get a bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/xpmwrap_skid_buf.sv
// Small register FIFO holding captured FIFO read data ahead of the stream port.
// Push and pop in the same cycle leave occupancy unchanged; head is the oldest entry.
module xpmwrap_skid_buf
  import xpmwrap_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OCC_W = clog2_min1(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [OCC_W-1:0] occ
);

  localparam int unsigned PTR_W = clog2_min1(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/xpmwrap_fifo_rd_stream.sv
// Read-side adapter for a standard-mode (latency 1) FIFO: issues credit-limited reads,
// buffers returning data and presents it as a valid/ready stream with optional framing.
module xpmwrap_fifo_rd_stream
  import xpmwrap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUF_DEPTH  = 2,
  parameter int unsigned PKT_LEN    = 0,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  input  logic                  fifo_rd_rst_busy,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic                  busy
);

  localparam int unsigned OCC_W = clog2_min1(BUF_DEPTH + 1);
  localparam int unsigned CR_W  = OCC_W + 1;

  logic             inflight_q;
  logic [OCC_W-1:0] occ;
  logic             pop;
  logic             credit_ok;

  assign m_valid = (occ != '0);
  assign pop     = m_valid & m_ready;

  // occ + inflight - pop < DEPTH, rearranged so nothing goes negative
  assign credit_ok  = ({1'b0, occ} + CR_W'(inflight_q)) < (CR_W'(BUF_DEPTH) + CR_W'(pop));
  assign fifo_rd_en = !fifo_empty && !fifo_rd_rst_busy && !rst && credit_ok;

  always_ff @(posedge wr_clk) begin
    if (rst) inflight_q <= 1'b0;
    else     inflight_q <= fifo_rd_en;
  end

  xpmwrap_skid_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (DATA_WIDTH),
    .OCC_W (OCC_W)
  ) u_buf (
    .clk       (wr_clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (fifo_dout),
    .pop       (pop),
    .head      (m_data),
    .occ       (occ)
  );

  always_ff @(posedge wr_clk) begin
    if (rst)      beat_count <= '0;
    else if (pop) beat_count <= beat_count + 1'b1;
  end

  generate
    if (PKT_LEN > 0) begin : g_frame
      localparam int unsigned PK_W = clog2_min1(PKT_LEN);
      localparam logic [PK_W-1:0] PK_LAST = PK_W'(PKT_LEN - 1);
      logic [PK_W-1:0] pkt_cnt;

      always_ff @(posedge wr_clk) begin
        if (rst)      pkt_cnt <= '0;
        else if (pop) pkt_cnt <= (pkt_cnt == PK_LAST) ? '0 : pkt_cnt + 1'b1;
      end

      assign m_last = m_valid && (pkt_cnt == PK_LAST);
    end else begin : g_noframe
      assign m_last = 1'b0;
    end
  endgenerate

  assign busy = (occ != '0) | inflight_q;

endmodule

// File: tb/tb_xpmwrap_fifo_rd_stream.sv
// Directed bench for xpmwrap_fifo_rd_stream with a latency-1 FIFO model in front of it.
module tb_xpmwrap_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fifo_dout = '0;
  logic        fifo_empty;
  logic        fifo_rd_rst_busy = 1'b0;
  logic        fifo_rd_en;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic [15:0] beat_count;
  logic        busy;

  int vec = 0;
  int err = 0;
  int cyc = 0;
  int wr_total = 0;
  int rd_total = 0;
  int uflow = 0;
  int proto = 0;

  logic [31:0] model_q [$];
  logic [31:0] rx_data [$];
  logic        rx_last [$];
  int          rx_cyc  [$];
  int          rd_cyc  [$];

  logic        p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0, p_rst = 1'b1;
  logic [31:0] p_data = '0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_total == rd_total);

  xpmwrap_fifo_rd_stream #(
    .DATA_WIDTH (32),
    .BUF_DEPTH  (2),
    .PKT_LEN    (4),
    .CNT_WIDTH  (16)
  ) dut (
    .wr_clk           (clk),
    .rst              (rst),
    .fifo_dout        (fifo_dout),
    .fifo_empty       (fifo_empty),
    .fifo_rd_rst_busy (fifo_rd_rst_busy),
    .fifo_rd_en       (fifo_rd_en),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_last           (m_last),
    .beat_count       (beat_count),
    .busy             (busy)
  );

  // FIFO model: standard read mode, dout registered one cycle after rd_en
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      model_q.delete();
      rd_total <= wr_total;
    end else if (fifo_rd_en) begin
      if (model_q.size() > 0) fifo_dout <= model_q.pop_front();
      rd_total <= rd_total + 1;
    end
  end

  // Observer: logs accepted beats, issued reads and stream-rule violations
  always @(negedge clk) begin
    if (m_valid && m_ready && !rst) begin
      rx_data.push_back(m_data);
      rx_last.push_back(m_last);
      rx_cyc.push_back(cyc);
    end
    if (fifo_rd_en) begin
      if (fifo_empty) uflow = uflow + 1;
      rd_cyc.push_back(cyc);
    end
    if (!rst && !p_rst && p_valid && !p_ready &&
        (!m_valid || m_data !== p_data || m_last !== p_last))
      proto = proto + 1;
    p_valid = m_valid;
    p_ready = m_ready;
    p_data  = m_data;
    p_last  = m_last;
    p_rst   = rst;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) model_q.push_back(base + 32'(i));
    wr_total = wr_total + n;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m_ready = 1'b0;
    tick(3);
    @(negedge clk);
    vec++; if (fifo_rd_en !== 1'b0) begin err++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    vec++; if (m_valid !== 1'b0) begin err++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    vec++; if (m_data !== 32'h0) begin err++; $display("FAIL reset_data: got %h want 0", m_data); end
    vec++; if (m_last !== 1'b0) begin err++; $display("FAIL reset_last: got %b want 0", m_last); end
    vec++; if (beat_count !== 16'd0) begin err++; $display("FAIL reset_beats: got %0d want 0", beat_count); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_stream;
    int b, rb;
    b = rx_data.size();
    rb = rd_cyc.size();
    m_ready = 1'b1;
    push_words(32'h0, 8);
    tick(16);
    @(negedge clk);
    vec++; if (rd_cyc.size() - rb != 8) begin err++; $display("FAIL stream_reads: got %0d want 8", rd_cyc.size() - rb); end
    vec++;
    if (rd_cyc.size() - rb != 8 || rd_cyc[rb+7] - rd_cyc[rb] != 7) begin
      err++; $display("FAIL stream_rd_consecutive: reads=%0d want 8 back-to-back", rd_cyc.size() - rb);
    end
    vec++; if (rx_data.size() - b != 8) begin err++; $display("FAIL stream_beats: got %0d want 8", rx_data.size() - b); end
    if (rx_data.size() - b == 8 && rd_cyc.size() - rb >= 1) begin
      for (int i = 0; i < 8; i++) begin
        vec++;
        if (rx_data[b+i] !== 32'(i) || rx_cyc[b+i] != rd_cyc[rb] + 2 + i) begin
          err++;
          $display("FAIL stream_beat[%0d]: got %h at cycle %0d want %h at cycle %0d",
                   i, rx_data[b+i], rx_cyc[b+i], i, rd_cyc[rb] + 2 + i);
        end
      end
    end
    vec++; if (beat_count !== 16'd8) begin err++; $display("FAIL stream_count: got %0d want 8", beat_count); end
  endtask

  task automatic test_backpressure;
    int b, rb;
    b = rx_data.size();
    rb = rd_cyc.size();
    m_ready = 1'b0;
    push_words(32'h0, 5);
    tick(8);
    @(negedge clk);
    vec++; if (rd_cyc.size() - rb != 2) begin err++; $display("FAIL bp_reads: got %0d want 2", rd_cyc.size() - rb); end
    vec++; if (m_valid !== 1'b1) begin err++; $display("FAIL bp_valid: got %b want 1", m_valid); end
    vec++; if (m_data !== 32'h0) begin err++; $display("FAIL bp_data: got %h want 0", m_data); end
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL bp_busy: got %b want 1", busy); end
    tick(3);
    @(negedge clk);
    vec++;
    if (m_valid !== 1'b1 || m_data !== 32'h0) begin
      err++; $display("FAIL bp_hold: got valid=%b data=%h want valid=1 data=0", m_valid, m_data);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    tick(10);
    @(negedge clk);
    vec++; if (rx_data.size() - b != 5) begin err++; $display("FAIL bp_beats: got %0d want 5", rx_data.size() - b); end
    if (rx_data.size() - b == 5) begin
      for (int i = 0; i < 5; i++) begin
        vec++;
        if (rx_data[b+i] !== 32'(i) || rx_cyc[b+i] != rx_cyc[b] + i || rx_last[b+i] !== (i == 3)) begin
          err++;
          $display("FAIL bp_beat[%0d]: got %h last=%b cyc+%0d want %h last=%b cyc+%0d",
                   i, rx_data[b+i], rx_last[b+i], rx_cyc[b+i] - rx_cyc[b], i, (i == 3), i);
        end
      end
    end
    vec++; if (beat_count !== 16'd13) begin err++; $display("FAIL bp_count: got %0d want 13", beat_count); end
  endtask

  task automatic test_toggle;
    int b, uf0;
    b = rx_data.size();
    uf0 = uflow;
    m_ready = 1'b1;
    push_words(32'h10, 16);
    for (int i = 0; i < 40; i++) begin
      tick(1);
      m_ready = ~m_ready;
    end
    m_ready = 1'b1;
    tick(6);
    @(negedge clk);
    vec++; if (rx_data.size() - b != 16) begin err++; $display("FAIL toggle_beats: got %0d want 16", rx_data.size() - b); end
    if (rx_data.size() - b == 16) begin
      for (int i = 0; i < 16; i++) begin
        vec++;
        if (rx_data[b+i] !== 32'h10 + 32'(i)) begin
          err++; $display("FAIL toggle_beat[%0d]: got %h want %h", i, rx_data[b+i], 32'h10 + 32'(i));
        end
      end
    end
    vec++; if (uflow != uf0) begin err++; $display("FAIL toggle_underflow: got %0d reads on empty want 0", uflow - uf0); end
    vec++; if (proto != 0) begin err++; $display("FAIL toggle_stream_rules: got %0d violations want 0", proto); end
    vec++; if (beat_count !== 16'd29) begin err++; $display("FAIL toggle_count: got %0d want 29", beat_count); end
  endtask

  task automatic test_framing;
    int b;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    b = rx_data.size();
    m_ready = 1'b1;
    push_words(32'h20, 10);
    tick(16);
    @(negedge clk);
    vec++; if (rx_data.size() - b != 10) begin err++; $display("FAIL frame_beats: got %0d want 10", rx_data.size() - b); end
    if (rx_data.size() - b == 10) begin
      for (int i = 0; i < 10; i++) begin
        vec++;
        if (rx_last[b+i] !== (i == 3 || i == 7) || rx_data[b+i] !== 32'h20 + 32'(i)) begin
          err++;
          $display("FAIL frame_beat[%0d]: got %h last=%b want %h last=%b",
                   i, rx_data[b+i], rx_last[b+i], 32'h20 + 32'(i), (i == 3 || i == 7));
        end
      end
    end
    vec++; if (m_last !== 1'b0) begin err++; $display("FAIL frame_idle_last: got %b want 0", m_last); end
    // two more beats: with pkt_cnt left at 2, the second one closes the packet
    push_words(32'h2A, 2);
    tick(8);
    @(negedge clk);
    vec++;
    if (rx_data.size() - b != 12 || rx_last[b+10] !== 1'b0 || rx_last[b+11] !== 1'b1) begin
      err++; $display("FAIL frame_resume: got beats=%0d want 12 with last only on beat 11", rx_data.size() - b);
    end
    vec++; if (beat_count !== 16'd12) begin err++; $display("FAIL frame_count: got %0d want 12", beat_count); end
  endtask

  task automatic test_reset_mid;
    int b;
    m_ready = 1'b0;
    push_words(32'h40, 6);
    tick(6);
    @(negedge clk);
    vec++;
    if (busy !== 1'b1 || m_valid !== 1'b1) begin
      err++; $display("FAIL rstmid_pre: got busy=%b valid=%b want 1 1", busy, m_valid);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    vec++; if (fifo_rd_en !== 1'b0) begin err++; $display("FAIL rstmid_rd_en: got %b want 0", fifo_rd_en); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vec++; if (m_valid !== 1'b0) begin err++; $display("FAIL rstmid_valid: got %b want 0", m_valid); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    vec++; if (beat_count !== 16'd0) begin err++; $display("FAIL rstmid_count: got %0d want 0", beat_count); end
    b = rx_data.size();
    @(posedge clk); #1;
    m_ready = 1'b1;
    tick(5);
    @(negedge clk);
    vec++;
    if (rx_data.size() != b || m_valid !== 1'b0) begin
      err++; $display("FAIL rstmid_stale: got %0d beats valid=%b want 0 beats valid=0", rx_data.size() - b, m_valid);
    end
    push_words(32'h50, 2);
    tick(6);
    @(negedge clk);
    vec++;
    if (rx_data.size() - b != 2 || rx_data[b] !== 32'h50 || rx_data[b+1] !== 32'h51) begin
      err++; $display("FAIL rstmid_after: got %0d beats want 2 beats 50,51", rx_data.size() - b);
    end
  endtask

  task automatic test_rd_rst_busy;
    int b, rb, fall;
    m_ready = 1'b0;
    push_words(32'h60, 6);
    tick(5);
    b = rx_data.size();
    rb = rd_cyc.size();
    fifo_rd_rst_busy = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec++; if (fifo_rd_en !== 1'b0) begin err++; $display("FAIL rrb_hold[%0d]: got rd_en=%b want 0", i, fifo_rd_en); end
      @(posedge clk); #1;
    end
    vec++; if (rx_data.size() - b != 2) begin err++; $display("FAIL rrb_drain: got %0d beats want 2", rx_data.size() - b); end
    fifo_rd_rst_busy = 1'b0;
    @(negedge clk);
    fall = cyc;
    vec++; if (fifo_rd_en !== 1'b1) begin err++; $display("FAIL rrb_resume: got rd_en=%b want 1", fifo_rd_en); end
    tick(10);
    @(negedge clk);
    vec++;
    if (rd_cyc.size() - rb != 4 || rd_cyc[rb] != fall) begin
      err++; $display("FAIL rrb_reads: got %0d reads want 4 starting at cycle %0d", rd_cyc.size() - rb, fall);
    end
    vec++; if (rx_data.size() - b != 6) begin err++; $display("FAIL rrb_beats: got %0d want 6", rx_data.size() - b); end
    if (rx_data.size() - b == 6) begin
      for (int i = 0; i < 6; i++) begin
        vec++;
        if (rx_data[b+i] !== 32'h60 + 32'(i)) begin
          err++; $display("FAIL rrb_beat[%0d]: got %h want %h", i, rx_data[b+i], 32'h60 + 32'(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_framing();
    test_reset_mid();
    test_rd_rst_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
